// File: rtl/round_pkg.sv
// Shared types and width helpers for the round controller.
package round_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_KEY,
    JUDGE,
    RESULT,
    OVER
  } round_state_t;

  localparam int unsigned DEF_TICK_DIV     = 50_000_000;
  localparam int unsigned DEF_TIME_LIMIT   = 10;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_LIVES        = 3;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Strobe/result handshake between the round controller and the judge.
interface round_ctrl_if;
  logic judge_same;
  logic judge_diff;
  logic judge_win;
  logic judge_lose;

  modport master (output judge_same, judge_diff, input judge_win, judge_lose);
  modport slave  (input judge_same, judge_diff, output judge_win, judge_lose);
endinterface

// File: rtl/round_ctrl_key_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, press pulse on 1->0.
module key_debounce
  import round_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);
  localparam int unsigned CNT_W = width_for(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised sample disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/round_ctrl.sv
// Game-round sequencer: key conditioning, countdown, one judge strobe, score and lives.
module round_ctrl
  import round_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned TIME_LIMIT   = 10,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             key_same_n,
  input  logic                             key_diff_n,
  input  logic                             new_game,
  input  logic                             round_start,
  round_ctrl_if.master                     jdg,
  output logic                             round_done,
  output logic                             round_won,
  output logic                             timeout,
  output logic [width_for(TIME_LIMIT)-1:0] time_left,
  output logic [SCORE_W-1:0]               score,
  output logic [width_for(LIVES)-1:0]      lives,
  output logic                             busy,
  output logic                             game_over
);
  localparam int unsigned TL_W   = width_for(TIME_LIMIT);
  localparam int unsigned LV_W   = width_for(LIVES);
  localparam int unsigned TICK_W = width_for(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  // Index 0 is the "same" key, index 1 the "diff" key.
  logic [1:0] key_n, key_level, key_press;
  assign key_n = {key_diff_n, key_same_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n_i (key_n[gi]),
      .level_o (key_level[gi]),
      .press_o (key_press[gi])
    );
  end

  round_state_t      st_q, st_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TL_W-1:0]   time_left_q, time_left_d;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic [LV_W-1:0]   lives_q, lives_d, lives_dec;
  logic              won_q, won_d, timeout_q, timeout_d;
  logic              jsame_q, jsame_d, jdiff_q, jdiff_d;
  logic              expired, judge_ok;

  assign score_inc = (&score_q) ? score_q : score_q + 1'b1;
  assign lives_dec = (lives_q != '0) ? lives_q - 1'b1 : lives_q;
  assign expired   = (time_left_q == '0);
  // A contradictory judge answer (win and lose together) counts against the player.
  assign judge_ok  = jdg.judge_win & ~jdg.judge_lose;

  always_comb begin
    st_d        = st_q;
    tick_d      = tick_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    lives_d     = lives_q;
    won_d       = won_q;
    timeout_d   = timeout_q;
    jsame_d     = 1'b0;
    jdiff_d     = 1'b0;

    if (st_q == ARMED || st_q == WAIT_KEY) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (!expired) time_left_d = time_left_q - 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    unique case (st_q)
      IDLE: if (round_start) begin
        st_d        = ARMED;
        time_left_d = TL_W'(TIME_LIMIT);
        tick_d      = '0;
        won_d       = 1'b0;
        timeout_d   = 1'b0;
      end
      ARMED, WAIT_KEY: begin
        if (st_q == WAIT_KEY && (|key_press)) begin
          st_d    = JUDGE;
          jsame_d = key_press[0];
          jdiff_d = key_press[1];
        end else if (expired) begin
          st_d      = RESULT;
          timeout_d = 1'b1;
          won_d     = 1'b0;
          lives_d   = lives_dec;
        end else if (st_q == ARMED && (&key_level)) begin
          st_d = WAIT_KEY;
        end
      end
      JUDGE: begin
        st_d = RESULT;
        if (judge_ok) begin
          won_d   = 1'b1;
          score_d = score_inc;
        end else begin
          lives_d = lives_dec;
        end
      end
      RESULT:  st_d = (lives_q == '0) ? OVER : IDLE;
      OVER:    st_d = OVER;
      default: st_d = IDLE;
    endcase

    if (new_game) begin
      st_d        = IDLE;
      tick_d      = '0;
      time_left_d = '0;
      score_d     = '0;
      lives_d     = LV_W'(LIVES);
      won_d       = 1'b0;
      timeout_d   = 1'b0;
      jsame_d     = 1'b0;
      jdiff_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      tick_q      <= '0;
      time_left_q <= '0;
      score_q     <= '0;
      lives_q     <= LV_W'(LIVES);
      won_q       <= 1'b0;
      timeout_q   <= 1'b0;
      jsame_q     <= 1'b0;
      jdiff_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      tick_q      <= tick_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      won_q       <= won_d;
      timeout_q   <= timeout_d;
      jsame_q     <= jsame_d;
      jdiff_q     <= jdiff_d;
    end
  end

  assign jdg.judge_same = jsame_q;
  assign jdg.judge_diff = jdiff_q;
  assign round_done     = (st_q == RESULT);
  assign round_won      = won_q;
  assign timeout        = timeout_q;
  assign time_left      = time_left_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign busy           = (st_q == ARMED) || (st_q == WAIT_KEY) || (st_q == JUDGE) || (st_q == RESULT);
  assign game_over      = (st_q == OVER);

endmodule

// File: tb/tb_round_ctrl.sv
// Randomised and directed bench for round_ctrl against a behavioural round model.
module tb_round_ctrl;
  localparam int TICK_DIV   = 10;
  localparam int TIME_LIMIT = 3;
  localparam int DEB        = 4;
  localparam int LIVES      = 2;
  localparam int SCORE_W    = 2;
  localparam int SMAX       = (1 << SCORE_W) - 1;
  localparam int TL_W       = $clog2(TIME_LIMIT + 1);
  localparam int LV_W       = $clog2(LIVES + 1);

  localparam int P_IDLE = 0, P_ARMED = 1, P_WAIT = 2, P_JUDGE = 3, P_RESULT = 4, P_OVER = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic key_same_n, key_diff_n, new_game, round_start;
  logic round_done, round_won, timeout, busy, game_over;
  logic [TL_W-1:0]    time_left;
  logic [SCORE_W-1:0] score;
  logic [LV_W-1:0]    lives;
  bit puzzle_same;

  int n_checks = 0;
  int n_pass   = 0;
  int n_same = 0, n_diff = 0, n_both = 0, n_done = 0;

  always #5 clk = ~clk;

  round_ctrl_if jif ();

  function automatic bit judge_f(input bit s, input bit d, input bit corr_same);
    return (s != d) && (s == corr_same);
  endfunction

  assign jif.judge_win  = judge_f(jif.judge_same, jif.judge_diff, puzzle_same);
  assign jif.judge_lose = (jif.judge_same | jif.judge_diff) & ~jif.judge_win;

  round_ctrl #(
    .TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT), .DEBOUNCE_CYC(DEB),
    .LIVES(LIVES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_same_n(key_same_n), .key_diff_n(key_diff_n),
    .new_game(new_game), .round_start(round_start), .jdg(jif),
    .round_done(round_done), .round_won(round_won), .timeout(timeout),
    .time_left(time_left), .score(score), .lives(lives), .busy(busy), .game_over(game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int ph, m_score, m_lives, m_tl, m_cyc;
  bit m_won, m_to, m_js, m_jd;
  logic [DEB+1:0] h_s, h_d;   // raw key samples, bit 0 newest
  bit deb_s, deb_d, ev_s, ev_d;

  task automatic model_reset();
    ph = P_IDLE; m_score = 0; m_lives = LIVES; m_tl = 0; m_cyc = 0;
    m_won = 0; m_to = 0; m_js = 0; m_jd = 0;
    h_s = '1; h_d = '1; deb_s = 1; deb_d = 1; ev_s = 0; ev_d = 0;
  endtask

  // A key level is accepted once the DEB samples seen through the 2-cycle sync all disagree with it.
  task automatic key_step(input bit raw, inout logic [DEB+1:0] h, inout bit deb, output bit ev);
    h  = {h[DEB:0], raw};
    ev = 1'b0;
    if (h[DEB+1:2] == {DEB{~deb}}) begin
      deb = ~deb;
      ev  = !deb;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit s, d;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_js; d = m_jd; m_js = 0; m_jd = 0;
      if (new_game) begin
        ph = P_IDLE; m_score = 0; m_lives = LIVES; m_won = 0; m_to = 0; m_tl = 0;
      end else begin
        case (ph)
          P_IDLE: if (round_start) begin
            ph = P_ARMED; m_tl = TIME_LIMIT; m_cyc = 0; m_won = 0; m_to = 0;
          end
          P_ARMED, P_WAIT: begin
            if (ph == P_WAIT && (ev_s || ev_d)) begin
              ph = P_JUDGE; m_js = ev_s; m_jd = ev_d;
            end else if (m_tl == 0) begin
              ph = P_RESULT; m_to = 1; m_won = 0; m_lives--;
            end else if (ph == P_ARMED && deb_s && deb_d) begin
              ph = P_WAIT;
            end
            m_cyc++;
            m_tl = TIME_LIMIT - m_cyc / TICK_DIV;
            if (m_tl < 0) m_tl = 0;
          end
          P_JUDGE: begin
            ph = P_RESULT;
            if (judge_f(s, d, puzzle_same)) begin
              m_won = 1;
              if (m_score < SMAX) m_score++;
            end else begin
              m_lives--;
            end
          end
          P_RESULT: ph = (m_lives == 0) ? P_OVER : P_IDLE;
          default: ;
        endcase
      end
      key_step(key_same_n, h_s, deb_s, ev_s);
      key_step(key_diff_n, h_d, deb_d, ev_d);
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  always @(negedge clk) begin
    check("time_left",  int'(time_left),  m_tl);
    check("score",      int'(score),      m_score);
    check("lives",      int'(lives),      m_lives);
    check("round_won",  int'(round_won),  int'(m_won));
    check("timeout",    int'(timeout),    int'(m_to));
    check("judge_same", int'(jif.judge_same), int'(m_js));
    check("judge_diff", int'(jif.judge_diff), int'(m_jd));
    check("round_done", int'(round_done), int'(ph == P_RESULT));
    check("busy",       int'(busy),       int'(ph >= P_ARMED && ph <= P_RESULT));
    check("game_over",  int'(game_over),  int'(ph == P_OVER));
    if (jif.judge_same) n_same++;
    if (jif.judge_diff) n_diff++;
    if (jif.judge_same && jif.judge_diff) n_both++;
    if (round_done) n_done++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_round(input bit corr);
    puzzle_same = corr;
    round_start = 1;
    cyc(1);
    round_start = 0;
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    cyc(1);
    new_game = 0;
  endtask

  task automatic play_round(input bit corr, input bit ps, input bit pd);
    start_round(corr);
    key_same_n = ~ps; key_diff_n = ~pd;
    cyc(6);
    key_same_n = 1; key_diff_n = 1;
    cyc(8);
  endtask

  initial begin
    int s0, d0, b0, r0;
    model_reset();
    rst_n = 0; key_same_n = 1; key_diff_n = 1; new_game = 0; round_start = 0; puzzle_same = 0;
    cyc(3);
    check("reset_score", int'(score), 0);
    check("reset_lives", int'(lives), 2);
    check("reset_busy",  int'(busy), 0);
    rst_n = 1;
    pulse_new_game();
    cyc(2);

    // Win round with the "same" key.
    s0 = n_same;
    play_round(1, 1, 0);
    check("win_strobe_cycles", n_same - s0, 1);
    check("win_score", int'(score), 1);
    check("win_lives", int'(lives), 2);
    check("win_round_won", int'(round_won), 1);

    // Timeout round.
    s0 = n_same + n_diff; r0 = n_done;
    start_round(1);
    cyc(40);
    check("to_timeout", int'(timeout), 1);
    check("to_lives", int'(lives), 1);
    check("to_time_left", int'(time_left), 0);
    check("to_no_strobe", n_same + n_diff - s0, 0);
    check("to_done_pulses", n_done - r0, 1);

    // Both keys together loses the last life.
    b0 = n_both;
    play_round(1, 1, 1);
    check("both_strobe", n_both - b0, 1);
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    start_round(0);
    cyc(3);
    check("over_ignores_start", int'(busy), 0);
    check("over_stays", int'(game_over), 1);
    pulse_new_game();
    cyc(2);
    check("ng_score", int'(score), 0);
    check("ng_lives", int'(lives), 2);
    check("ng_over", int'(game_over), 0);

    // Key held across round_start, then a short glitch, then a real press.
    s0 = n_same + n_diff;
    key_diff_n = 0;
    cyc(8);
    start_round(0);
    cyc(4);
    check("held_busy", int'(busy), 1);
    check("held_no_strobe", n_same + n_diff - s0, 0);
    key_diff_n = 1;
    cyc(7);
    key_same_n = 0;
    cyc(3);
    key_same_n = 1;
    cyc(2);
    check("glitch_no_strobe", n_same + n_diff - s0, 0);
    key_diff_n = 0;
    cyc(6);
    key_diff_n = 1;
    cyc(6);
    check("held_win_score", int'(score), 1);
    check("held_win_flag", int'(round_won), 1);

    // new_game beats round_start in the same cycle.
    new_game = 1; round_start = 1;
    cyc(1);
    new_game = 0; round_start = 0;
    cyc(2);
    check("prio_busy", int'(busy), 0);

    // Press event lands in the same cycle time_left hits 0.
    s0 = n_same;
    start_round(1'($urandom_range(0, 1)));
    cyc(24);
    key_same_n = 0;
    cyc(6);
    key_same_n = 1;
    cyc(6);
    check("coinc_timeout", int'(timeout), 0);
    check("coinc_strobe", n_same - s0, 1);

    // Reset in the middle of a round.
    start_round(1);
    cyc(4);
    rst_n = 0;
    cyc(2);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_lives", int'(lives), 2);
    rst_n = 1;
    r0 = n_done;
    cyc(40);
    check("mid_rst_no_done", n_done - r0, 0);

    // Score saturates at 2^SCORE_W-1.
    pulse_new_game();
    cyc(2);
    repeat (4) play_round(1, 1, 0);
    check("sat_score", int'(score), SMAX);
    check("sat_lives", int'(lives), 2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) key_same_n = ~key_same_n;
      if ($urandom_range(0, 7) == 0) key_diff_n = ~key_diff_n;
      round_start = ($urandom_range(0, 24) == 0);
      if (round_start) puzzle_same = 1'($urandom_range(0, 1));
      new_game = ($urandom_range(0, 299) == 0);
      rst_n    = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    rst_n = 1; new_game = 0; round_start = 0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
